ingress_buffer: RTL

Per-port ingress queue for the 4-port switch: accepts packets from the link side, stores them in a FIFO and presents the head packet's request and destination mask to the central arbiter. One instance per input port; its port_req/port_dst feed one slot of the arbiter's port_reqs/portN_dst, and its grant input is the matching bit of grant_bus. On grant it pops the head and drives the packet toward the crossbar one cycle later, aligned with the arbiter's registered mux_sel/active outputs.

---
 rtl/packet_pkg.sv | 15 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/ingress_buffer.sv | 88 ++++++++
 3 files changed

// File: rtl/packet_pkg.sv
// rtl/packet_pkg.sv - packet format and sizing constants shared by the switch ingress path
package packet_pkg;

  localparam int ADDR_WIDTH    = 4;
  localparam int SRC_WIDTH     = 2;
  localparam int PAYLOAD_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    dst;
    logic [SRC_WIDTH-1:0]     src;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } packet_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count, full/empty derived from level
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp_q];

  // Pointer advance wraps naturally because DEPTH is a power of two
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    if (do_push) wp_d = wp_q + 1'b1;
    if (do_pop)  rp_d = rp_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
    end
  end

  // Storage array; contents are meaningless while empty so it carries no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wp_q] <= wdata;
  end

endmodule

// File: rtl/ingress_buffer.sv
// rtl/ingress_buffer.sv - per-port ingress queue presenting head request to the arbiter
module ingress_buffer
  import packet_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  packet_t               in_pkt,
  output logic                  port_req,
  output logic [ADDR_WIDTH-1:0] port_dst,
  input  logic                  grant,
  output logic                  out_valid,
  output packet_t               out_pkt,
  output logic [CNT_WIDTH-1:0]  tx_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [$clog2(DEPTH):0] level
);

  packet_t              head;
  logic                 full, empty;
  logic                 take, drop, push;
  logic                 out_valid_q, out_valid_d;
  packet_t              out_pkt_q, out_pkt_d;
  logic [CNT_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // A full buffer refuses input even when the head leaves this cycle
  assign push = in_valid && !full;

  sync_fifo #(
    .WIDTH ($bits(packet_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_pkt),
    .pop   (take || drop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Head qualification: a packet with no destinations never requests and is discarded
  always_comb begin
    port_req = !empty && (|head.dst);
    port_dst = empty ? '0 : head.dst;
    take     = grant && port_req;
    drop     = !empty && (head.dst == '0);
  end

  // Output staging and saturating statistics
  always_comb begin
    out_valid_d = take;
    out_pkt_d   = take ? head : out_pkt_q;
    tx_cnt_d    = tx_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (take && (tx_cnt_q != '1))   tx_cnt_d   = tx_cnt_q + 1'b1;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
      tx_cnt_q    <= '0;
      drop_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pkt_q   <= out_pkt_d;
      tx_cnt_q    <= tx_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign in_ready  = !full;
  assign out_valid = out_valid_q;
  assign out_pkt   = out_pkt_q;
  assign tx_cnt    = tx_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
